axi_master_fsm: RTL and testbench
=================================

# axi_master_fsm

Single-outstanding AXI-style initiator. It accepts one read or write command from local logic, drives the AW/W/B or AR/R channels toward the team's `axi_slave_fsm`-compatible responders (including the custom `M_BLEN` read byte-enable), and returns one response pulse per command. It sits between the PS-side test and control logic and the switch/LED peripheral slaves.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: wait-state limit; used only when the watchdog is compiled in.

Ports, clock and reset first:
- `M_ACLK` in 1: clock. One clock domain; every register is on the rising edge.
- `M_ARESET` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address, passed through unmodified.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write byte strobes.
- `cmd_blen` in 4: read byte-enable mask.
- `M_AWVALID` out 1, `M_AWADDR` out 32, `S_AWREADY` in 1: AW channel.
- `M_WVALID` out 1, `M_WDATA` out 32, `M_WSTRB` out 4, `S_WREADY` in 1: W channel.
- `M_BREADY` out 1, `S_BVALID` in 1, `S_BRESP` in 2: B channel.
- `M_ARVALID` out 1, `M_ARADDR` out 32, `S_ARREADY` in 1: AR channel.
- `M_RREADY` out 1, `M_BLEN` out 4, `S_RVALID` in 1, `S_RDATA` in 32: R channel.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_write` out 1: type of the completed command.
- `rsp_resp` out 2: BRESP for writes; 2'b00 for normal reads; 2'b10 on timeout.
- `rsp_rdata` out 32: masked read data; 0 for writes.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE. One-hot encoding.
- IDLE: `cmd_ready`=1. If `cmd_valid`=1:
  - Latch all cmd fields into registers.
  - Go to WR_REQ if `cmd_write`=1, otherwise RD_REQ.
- WR_REQ:
  - `M_AWVALID` and `M_WVALID` both assert on entry and are handshaken independently.
  - Each valid drops the cycle after its own valid&&ready.
  - Once both handshakes are complete (same or different cycles), go to WR_RESP.
- WR_RESP: `M_BREADY`=1. On `S_BVALID`, capture `S_BRESP` into `rsp_resp` and go to DONE.
- RD_REQ: `M_ARVALID`=1 with `M_BLEN`=latched blen. On `S_ARREADY`, go to RD_DATA.
- RD_DATA:
  - `M_RREADY`=1 and `M_BLEN` stays held.
  - On `S_RVALID`, capture `S_RDATA`; byte k is zeroed where blen[k]=0. Go to DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, then go to IDLE. `rsp_*` fields hold their values until the next DONE.
- Outputs are registered and hold stable while valid is high; `M_*ADDR`/`M_WDATA`/`M_WSTRB` are stable from valid assertion to handshake.
- `M_BLEN`=0 outside RD_REQ and RD_DATA.
- `cmd_valid` is ignored outside IDLE, so there is no queuing.

## Timing
- Reset value of every output is 0, applied immediately and asynchronously, including mid-transaction. All channel valids and readies drop and the in-flight command is lost; no response is generated.
- Write with zero-wait slave: accept at cycle 0; AW/W valid at cycle 1; WR_RESP at 2; BVALID seen at 2; `rsp_valid` at cycle 3. Four cycles cmd-to-cmd.
- Read with zero-wait slave: accept at 0; ARVALID at 1; RD_DATA at 2; `rsp_valid` at 3.
- A valid is never withdrawn before its handshake, except on timeout or reset.
- Simultaneous AW and W ready: both complete in one cycle.
- W ready before AW: `M_WVALID` drops and the FSM waits for AW alone.

## Configuration
- Macro: `AXI_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA. It clears on each state change.
  - When it reaches `TIMEOUT_CYCLES`: all channel valids and readies go to 0, then DONE with `rsp_resp`=2'b10 and `rsp_rdata`=0.
- Undefined: the FSM waits indefinitely; the counter logic is absent.

## Structure
- Shared package `axi_pkg`:
  - State encodings.
  - Response constants OKAY=2'b00, SLVERR=2'b10.
  - Channel width localparams (ADDR_W=32, DATA_W=32, STRB_W=4).
- Sub-module `axi_master_watchdog`: the timeout counter with `clr` and `en` inputs and a `expired` output. It is instantiated only under `AXI_MASTER_TIMEOUT_EN`.

## Test plan
- Write addr 0x4, wdata 0xA5A5_1234, wstrb 4'hF, zero-wait slave -> AW/W valid at cycle 1, `rsp_valid` at cycle 3, `rsp_resp`=2'b00.
- Write with S_WREADY 2 cycles before S_AWREADY -> `M_WVALID` drops after its handshake, `M_AWVALID` held until its own, then one B handshake and one `rsp_valid`.
- Read addr 0x8, blen 4'b0101, slave returns 0xDEAD_BEEF -> `M_BLEN`=4'b0101 during AR/R, `rsp_rdata`=0x00AD_00EF.
- S_BVALID with S_BRESP=2'b10 -> `rsp_resp`=2'b10, `rsp_write`=1.
- Assert M_ARESET while `M_ARVALID` is high -> all outputs 0 in the same cycle; after release the FSM is in IDLE with `cmd_ready`=1 and no `rsp_valid`.
- With `AXI_MASTER_TIMEOUT_EN`, TIMEOUT_CYCLES=8, S_ARREADY tied low -> `M_ARVALID` drops after 8 cycles, `rsp_valid` with `rsp_resp`=2'b10, `rsp_rdata`=0.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: definitions shared by the AXI-style initiator and its helpers.
//   - state_e       : one-hot state encoding of axi_master_fsm
//   - OKAY / SLVERR : response codes
//   - ADDR_W, DATA_W, STRB_W : channel widths
//   - mask_bytes()  : zero every data byte whose enable bit is clear
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_WR_REQ  = 6'b000010,
        ST_WR_RESP = 6'b000100,
        ST_RD_REQ  = 6'b001000,
        ST_RD_DATA = 6'b010000,
        ST_DONE    = 6'b100000
    } state_e;

    function automatic logic [DATA_W-1:0] mask_bytes(
        input logic [DATA_W-1:0] data,
        input logic [STRB_W-1:0] en
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < STRB_W; k++) begin
            if (en[k]) r[k*8 +: 8] = data[k*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_master_fsm_if.sv
// axi_master_fsm_if: AW/W/B/AR/R channel bundle between the initiator and an
// axi_slave_fsm-compatible responder. M_* signals are driven by the master,
// S_* signals by the slave. M_BLEN is the custom read byte-enable.
//   modport master : drives M_*, samples S_*
//   modport slave  : drives S_*, samples M_*
interface axi_master_fsm_if;
    import axi_pkg::*;

    logic              M_AWVALID;
    logic [ADDR_W-1:0] M_AWADDR;
    logic              S_AWREADY;

    logic              M_WVALID;
    logic [DATA_W-1:0] M_WDATA;
    logic [STRB_W-1:0] M_WSTRB;
    logic              S_WREADY;

    logic              M_BREADY;
    logic              S_BVALID;
    logic [1:0]        S_BRESP;

    logic              M_ARVALID;
    logic [ADDR_W-1:0] M_ARADDR;
    logic              S_ARREADY;

    logic              M_RREADY;
    logic [STRB_W-1:0] M_BLEN;
    logic              S_RVALID;
    logic [DATA_W-1:0] S_RDATA;

    modport master (
        output M_AWVALID, M_AWADDR, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
               M_ARVALID, M_ARADDR, M_RREADY, M_BLEN,
        input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID, S_RDATA
    );

    modport slave (
        input  M_AWVALID, M_AWADDR, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
               M_ARVALID, M_ARADDR, M_RREADY, M_BLEN,
        output S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID, S_RDATA
    );

endinterface

// File: rtl/axi_master_watchdog.sv
// axi_master_watchdog: wait-state counter for axi_master_fsm.
//   M_ACLK, M_ARESET : clock, asynchronous active-high reset
//   clr              : restart the count (state change or not waiting)
//   en               : count this cycle
//   expired          : the current state has been held TIMEOUT_CYCLES cycles
module axi_master_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic M_ACLK,
    input  logic M_ARESET,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned    CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count starts at 0 on the first cycle of a state, so the
    // TIMEOUT_CYCLES-th cycle spent there sees LAST.
    assign expired = en && (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge M_ACLK or posedge M_ARESET) begin
        if (M_ARESET) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/axi_master_fsm.sv
// axi_master_fsm: single-outstanding AXI-style initiator.
// Accepts one command on cmd_*, runs it on the AW/W/B or AR/R channels of
// `bus`, and reports completion with a one-cycle rsp_valid pulse.
//   M_ACLK, M_ARESET : clock, asynchronous active-high reset
//   cmd_*            : command request (cmd_ready high only in IDLE)
//   bus              : axi_master_fsm_if.master channel bundle
//   rsp_*            : completion pulse, type, response code, masked read data
// Optional feature: define AXI_MASTER_TIMEOUT_EN to abort any state that
// waits TIMEOUT_CYCLES cycles; the command then completes with SLVERR.
module axi_master_fsm
    import axi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                M_ACLK,
    input  logic                M_ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [STRB_W-1:0]   cmd_wstrb,
    input  logic [STRB_W-1:0]   cmd_blen,
    axi_master_fsm_if.master    bus,
    output logic                rsp_valid,
    output logic                rsp_write,
    output logic [1:0]          rsp_resp,
    output logic [DATA_W-1:0]   rsp_rdata
);
    state_e            state_q;
    logic              cmd_ready_q;
    logic              awvalid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic              wvalid_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              bready_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              rready_q;
    logic [STRB_W-1:0] blen_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [1:0]        rsp_resp_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic aw_hs;
    logic w_hs;
    logic wr_req_done;
    logic expired;

    assign aw_hs = awvalid_q && bus.S_AWREADY;
    assign w_hs  = wvalid_q  && bus.S_WREADY;
    // Each of AW and W is either already done (valid dropped) or completes now.
    assign wr_req_done = (!awvalid_q || bus.S_AWREADY) && (!wvalid_q || bus.S_WREADY);

`ifdef AXI_MASTER_TIMEOUT_EN
    logic active;
    logic leave;
    logic wd_clr;

    assign active = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                    (state_q == ST_RD_REQ)  || (state_q == ST_RD_DATA);
    assign leave  = ((state_q == ST_WR_REQ)  && wr_req_done)   ||
                    ((state_q == ST_WR_RESP) && bus.S_BVALID)  ||
                    ((state_q == ST_RD_REQ)  && bus.S_ARREADY) ||
                    ((state_q == ST_RD_DATA) && bus.S_RVALID);
    assign wd_clr = !active || leave || expired;

    axi_master_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .M_ACLK  (M_ACLK),
        .M_ARESET(M_ARESET),
        .clr     (wd_clr),
        .en      (active),
        .expired (expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge M_ACLK or posedge M_ARESET) begin
        // NOTE: async reset clears every output register so all channel valids
        // drop the instant reset rises, even mid-transaction.
        if (M_ARESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            blen_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= OKAY;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking throughout, so later assignments in this
            // block override this default without reordering hazards.
            rsp_valid_q <= 1'b0;

            if (expired) begin
                // Abandon the in-flight handshake and complete with SLVERR.
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                blen_q      <= '0;
                rsp_valid_q <= 1'b1;
                rsp_write_q <= (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP);
                rsp_resp_q  <= SLVERR;
                rsp_rdata_q <= '0;
                state_q     <= ST_DONE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        cmd_ready_q <= 1'b1;
                        if (cmd_valid && cmd_ready_q) begin
                            cmd_ready_q <= 1'b0;
                            if (cmd_write) begin
                                awvalid_q <= 1'b1;
                                awaddr_q  <= cmd_addr;
                                wvalid_q  <= 1'b1;
                                wdata_q   <= cmd_wdata;
                                wstrb_q   <= cmd_wstrb;
                                state_q   <= ST_WR_REQ;
                            end else begin
                                arvalid_q <= 1'b1;
                                araddr_q  <= cmd_addr;
                                blen_q    <= cmd_blen;
                                state_q   <= ST_RD_REQ;
                            end
                        end
                    end

                    ST_WR_REQ: begin
                        if (aw_hs) awvalid_q <= 1'b0;
                        if (w_hs)  wvalid_q  <= 1'b0;
                        if (wr_req_done) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end
                    end

                    ST_WR_RESP: begin
                        if (bus.S_BVALID) begin
                            bready_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_write_q <= 1'b1;
                            rsp_resp_q  <= bus.S_BRESP;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_DONE;
                        end
                    end

                    ST_RD_REQ: begin
                        if (bus.S_ARREADY) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= ST_RD_DATA;
                        end
                    end

                    ST_RD_DATA: begin
                        if (bus.S_RVALID) begin
                            rready_q    <= 1'b0;
                            blen_q      <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_write_q <= 1'b0;
                            rsp_resp_q  <= OKAY;
                            rsp_rdata_q <= mask_bytes(bus.S_RDATA, blen_q);
                            state_q     <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign bus.M_AWVALID = awvalid_q;
    assign bus.M_AWADDR  = awaddr_q;
    assign bus.M_WVALID  = wvalid_q;
    assign bus.M_WDATA   = wdata_q;
    assign bus.M_WSTRB   = wstrb_q;
    assign bus.M_BREADY  = bready_q;
    assign bus.M_ARVALID = arvalid_q;
    assign bus.M_ARADDR  = araddr_q;
    assign bus.M_RREADY  = rready_q;
    assign bus.M_BLEN    = blen_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_axi_master_fsm.sv
// tb_axi_master_fsm: directed self-checking bench for axi_master_fsm.
// A table of zero-wait-slave commands, then hand-written sequences for
// skewed W/AW readies, the optional timeout and a mid-read reset.
module tb_axi_master_fsm;
    import axi_pkg::*;

    localparam int unsigned TO_CYCLES = 8;

    logic        M_ACLK = 1'b0;
    logic        M_ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [3:0]  cmd_blen;
    logic        rsp_valid;
    logic        rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;

    axi_master_fsm_if bus ();

    axi_master_fsm #(
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .M_ACLK   (M_ACLK),
        .M_ARESET (M_ARESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .cmd_blen (cmd_blen),
        .bus      (bus),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_resp (rsp_resp),
        .rsp_rdata(rsp_rdata)
    );

    always #5 M_ACLK = ~M_ACLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  blen;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];
    int   total = 0;
    int   bad   = 0;
    int   pulses;
    int   hi_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge M_ACLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    // Presents one command for one edge; returns at cycle 1 (#1 after the edge
    // following acceptance). Inputs are scrambled afterwards so the bench sees
    // whether the DUT latched them.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [3:0] blen);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        cmd_blen  = blen;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_wstrb = 4'h0;
        cmd_blen  = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] ctl;
        ctl = 32'({cmd_ready, rsp_valid, rsp_write, rsp_resp, bus.M_AWVALID, bus.M_WVALID,
                   bus.M_WSTRB, bus.M_BREADY, bus.M_ARVALID, bus.M_RREADY, bus.M_BLEN});
        check({tag, "_ctl"},    ctl, 32'd0);
        check({tag, "_awaddr"}, bus.M_AWADDR, 32'd0);
        check({tag, "_wdata"},  bus.M_WDATA,  32'd0);
        check({tag, "_araddr"}, bus.M_ARADDR, 32'd0);
        check({tag, "_rdata"},  rsp_rdata,    32'd0);
    endtask

    task automatic slave_idle();
        bus.S_AWREADY = 1'b0;
        bus.S_WREADY  = 1'b0;
        bus.S_BVALID  = 1'b0;
        bus.S_BRESP   = 2'b00;
        bus.S_ARREADY = 1'b0;
        bus.S_RVALID  = 1'b0;
        bus.S_RDATA   = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        //          wr    addr          wdata         wstrb blen     bresp  rdata         resp   exp_rdata
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF, 4'h0,    2'b00, 32'h0,        2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 4'b0101, 2'b00, 32'hDEAD_BEEF, 2'b00, 32'h00AD_00EF};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'h3, 4'h0,    2'b10, 32'h0,        2'b10, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 4'b1111, 2'b00, 32'h1234_5678, 2'b00, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 4'b0000, 2'b00, 32'hFFFF_FFFF, 2'b00, 32'h0};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 4'b1010, 2'b00, 32'hCAFE_F00D, 2'b00, 32'hCA00_F000};

        M_ARESET  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        cmd_blen  = 4'h0;
        slave_idle();

        // Reset state.
        #2;
        check_all_zero("rst0");
        @(posedge M_ACLK);
        @(posedge M_ACLK);
        #1;
        M_ARESET = 1'b0;
        tick();
        check("rst0_cmd_ready_after", 32'(cmd_ready), 32'd1);

        // Table: zero-wait slave, every handshake completes on first offer.
        for (int i = 0; i < 6; i++) begin
            bus.S_AWREADY = 1'b1;
            bus.S_WREADY  = 1'b1;
            bus.S_ARREADY = 1'b1;
            bus.S_BVALID  = 1'b1;
            bus.S_RVALID  = 1'b1;
            bus.S_BRESP   = vecs[i].bresp;
            bus.S_RDATA   = vecs[i].rdata;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].blen);
            // cycle 1
            check($sformatf("v%0d_c1_cmd_ready", i), 32'(cmd_ready), 32'd0);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_c1_awvalid", i), 32'(bus.M_AWVALID), 32'd1);
                check($sformatf("v%0d_c1_wvalid", i),  32'(bus.M_WVALID),  32'd1);
                check($sformatf("v%0d_c1_awaddr", i),  bus.M_AWADDR, vecs[i].addr);
                check($sformatf("v%0d_c1_wdata", i),   bus.M_WDATA,  vecs[i].wdata);
                check($sformatf("v%0d_c1_wstrb", i),   32'(bus.M_WSTRB), 32'(vecs[i].wstrb));
                check($sformatf("v%0d_c1_blen", i),    32'(bus.M_BLEN),  32'd0);
            end else begin
                check($sformatf("v%0d_c1_arvalid", i), 32'(bus.M_ARVALID), 32'd1);
                check($sformatf("v%0d_c1_araddr", i),  bus.M_ARADDR, vecs[i].addr);
                check($sformatf("v%0d_c1_blen", i),    32'(bus.M_BLEN), 32'(vecs[i].blen));
            end
            tick();
            // cycle 2
            check($sformatf("v%0d_c2_rsp_valid", i), 32'(rsp_valid), 32'd0);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_c2_bready", i),  32'(bus.M_BREADY), 32'd1);
                check($sformatf("v%0d_c2_awvalid", i), 32'(bus.M_AWVALID), 32'd0);
            end else begin
                check($sformatf("v%0d_c2_rready", i),  32'(bus.M_RREADY), 32'd1);
                check($sformatf("v%0d_c2_blen", i),    32'(bus.M_BLEN), 32'(vecs[i].blen));
            end
            tick();
            // cycle 3
            check($sformatf("v%0d_c3_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_c3_rsp_write", i), 32'(rsp_write), 32'(vecs[i].wr));
            check($sformatf("v%0d_c3_rsp_resp", i),  32'(rsp_resp),  32'(vecs[i].exp_resp));
            check($sformatf("v%0d_c3_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            tick();
            // cycle 4
            check($sformatf("v%0d_c4_rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d_c4_cmd_ready", i), 32'(cmd_ready), 32'd1);
            check($sformatf("v%0d_c4_blen", i),      32'(bus.M_BLEN), 32'd0);
            check($sformatf("v%0d_c4_rdata_hold", i), rsp_rdata, vecs[i].exp_rdata);
        end
        slave_idle();

`ifdef AXI_MASTER_TIMEOUT_EN
        // Timeout: AR never accepted.
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 4'hF);
        hi_cycles = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.M_ARVALID === 1'b1) hi_cycles++;
            tick();
        end
        check("to_arvalid_cycles", 32'(hi_cycles), 32'd8);
        check("to_arvalid_dropped", 32'(bus.M_ARVALID), 32'd0);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_resp", 32'(rsp_resp), 32'(SLVERR));
        check("to_rsp_rdata", rsp_rdata, 32'd0);
        check("to_rsp_write", 32'(rsp_write), 32'd0);
        check("to_blen", 32'(bus.M_BLEN), 32'd0);
        tick();
        check("to_rsp_valid_after", 32'(rsp_valid), 32'd0);
        check("to_cmd_ready_after", 32'(cmd_ready), 32'd1);
`endif

        // W ready two cycles before AW ready.
        slave_idle();
        issue(1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'b0110, 4'h0);
        bus.S_WREADY = 1'b1;                               // cycle 1
        check("skew_c1_awvalid", 32'(bus.M_AWVALID), 32'd1);
        check("skew_c1_wvalid",  32'(bus.M_WVALID),  32'd1);
        tick();                                            // cycle 2
        bus.S_WREADY = 1'b0;
        check("skew_c2_wvalid",  32'(bus.M_WVALID),  32'd0);
        check("skew_c2_awvalid", 32'(bus.M_AWVALID), 32'd1);
        check("skew_c2_bready",  32'(bus.M_BREADY),  32'd0);
        tick();                                            // cycle 3
        check("skew_c3_awvalid", 32'(bus.M_AWVALID), 32'd1);
        check("skew_c3_awaddr",  bus.M_AWADDR, 32'h0000_0100);
        bus.S_AWREADY = 1'b1;
        tick();                                            // cycle 4
        bus.S_AWREADY = 1'b0;
        check("skew_c4_awvalid", 32'(bus.M_AWVALID), 32'd0);
        check("skew_c4_bready",  32'(bus.M_BREADY),  32'd1);
        check("skew_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        bus.S_BVALID = 1'b1;
        bus.S_BRESP  = 2'b00;
        tick();                                            // cycle 5
        bus.S_BVALID = 1'b0;
        check("skew_c5_rsp_write", 32'(rsp_write), 32'd1);
        check("skew_c5_rsp_resp",  32'(rsp_resp),  32'd0);
        check("skew_c5_bready",    32'(bus.M_BREADY), 32'd0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid === 1'b1) pulses++;
            tick();
        end
        check("skew_rsp_pulses", 32'(pulses), 32'd1);

        // Zero-wait read to leave non-zero response data behind.
        bus.S_ARREADY = 1'b1;
        bus.S_RVALID  = 1'b1;
        bus.S_RDATA   = 32'h1122_3344;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 4'b1100);
        tick();
        tick();
        check("pre_rst_rdata", rsp_rdata, 32'h1122_0000);
        tick();
        slave_idle();

        // Reset while ARVALID is high.
        issue(1'b0, 32'h0000_000C, 32'h0, 4'h0, 4'b0011);
        tick();                                            // cycle 2, AR stalled
        check("rst_pre_arvalid", 32'(bus.M_ARVALID), 32'd1);
        M_ARESET = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge M_ACLK);
        @(posedge M_ACLK);
        #1;
        M_ARESET = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid === 1'b1) pulses++;
        end
        check("rst_no_rsp", 32'(pulses), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_arvalid_low", 32'(bus.M_ARVALID), 32'd0);

        // Recovery read after reset.
        bus.S_ARREADY = 1'b1;
        bus.S_RVALID  = 1'b1;
        bus.S_RDATA   = 32'hA1B2_C3D4;
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h0, 4'b1001);
        tick();
        tick();
        check("rec_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rec_rsp_rdata", rsp_rdata, 32'hA100_00D4);
        tick();
        slave_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
